// File: rtl/sram_wb_cmd_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the byte-stream
// to Wishbone command master.
package sram_wb_cmd_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h45;

   typedef enum logic [2:0] {
      GET_OP    = 3'd0,
      GET_ADDR  = 3'd1,
      GET_DATA  = 3'd2,
      WB_REQ    = 3'd3,
      RESP      = 3'd4,
      SEND_DATA = 3'd5
   } state_e;

endpackage

// File: rtl/sram_wb_cmd_master.sv
// Byte-stream command decoder issuing single Wishbone reads/writes; all outputs registered,
// one byte per handshake; RX stalls outside command collection, TX bytes held until accepted.
module sram_wb_cmd_master
   import sram_wb_cmd_pkg::*;
#(
   parameter int ADDR_WD = 8,
   parameter int DATA_WD = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 rx_valid_i,
   output logic                 rx_ready_o,
   output logic [7:0]           tx_data_o,
   output logic                 tx_valid_o,
   input  logic                 tx_ready_i,
   output logic                 wbm_cyc_o,
   output logic                 wbm_stb_o,
   output logic                 wbm_we_o,
   output logic [ADDR_WD-1:0]   wbm_adr_o,
   output logic [DATA_WD-1:0]   wbm_dat_o,
   output logic [DATA_WD/8-1:0] wbm_sel_o,
   input  logic [DATA_WD-1:0]   wbm_dat_i,
   input  logic                 wbm_ack_i,
   output logic                 busy_o,
   output logic                 err_o
);

   localparam int ADDR_BYTES = (ADDR_WD + 7) / 8;
   localparam int DATA_BYTES = DATA_WD / 8;
   localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int BC_WD      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES + 1) : 1;
   localparam int TMO_WD     = $clog2(TIMEOUT + 1);

   state_e                    state_q, state_d;
   logic [BC_WD-1:0]          byte_cnt_q, byte_cnt_d;
   logic [TMO_WD-1:0]         tmo_q, tmo_d;
   logic [ADDR_BYTES*8-1:0]   addr_q, addr_d;
   logic [DATA_WD-1:0]        wdat_q, wdat_d;
   logic [DATA_WD-1:0]        rdat_q, rdat_d;
   logic                      we_q, we_d;
   logic                      cyc_q, cyc_d;
   logic [7:0]                tx_data_q, tx_data_d;
   logic                      tx_valid_q, tx_valid_d;
   logic                      rx_ready_q, rx_ready_d;
   logic                      busy_q, busy_d;
   logic                      err_q, err_d;

   logic                      rx_fire;
   logic                      tx_fire;
   logic [BC_WD-1:0]          byte_cnt_inc;
   logic [TMO_WD-1:0]         tmo_inc;

   assign rx_fire      = rx_valid_i && rx_ready_q;
   assign tx_fire      = tx_valid_q && tx_ready_i;
   assign byte_cnt_inc = byte_cnt_q + BC_WD'(1);
   assign tmo_inc      = tmo_q + TMO_WD'(1);

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      tmo_d      = tmo_q;
      addr_d     = addr_q;
      wdat_d     = wdat_q;
      rdat_d     = rdat_q;
      we_d       = we_q;
      cyc_d      = cyc_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      err_d      = 1'b0;

      case (state_q)
         GET_OP: begin
            if (rx_fire) begin
               if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                  we_d       = (rx_data_i == OP_WRITE);
                  byte_cnt_d = '0;
                  state_d    = GET_ADDR;
               end else begin
                  tx_data_d  = RSP_ERR;
                  tx_valid_d = 1'b1;
                  err_d      = 1'b1;
                  state_d    = RESP;
               end
            end
         end

         GET_ADDR: begin
            if (rx_fire) begin
               for (int i = 0; i < ADDR_BYTES; i++) begin
                  if (byte_cnt_q == BC_WD'(i)) addr_d[i*8 +: 8] = rx_data_i;
               end
               if (byte_cnt_q == BC_WD'(ADDR_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  state_d    = we_q ? GET_DATA : WB_REQ;
               end else begin
                  byte_cnt_d = byte_cnt_inc;
               end
            end
         end

         GET_DATA: begin
            if (rx_fire) begin
               for (int i = 0; i < DATA_BYTES; i++) begin
                  if (byte_cnt_q == BC_WD'(i)) wdat_d[i*8 +: 8] = rx_data_i;
               end
               if (byte_cnt_q == BC_WD'(DATA_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  state_d    = WB_REQ;
               end else begin
                  byte_cnt_d = byte_cnt_inc;
               end
            end
         end

         WB_REQ: begin
            // First cycle in WB_REQ only raises the strobe; ack is honoured
            // strictly while our own strobe is up so stale acks never count.
            if (!cyc_q) begin
               cyc_d = 1'b1;
               tmo_d = '0;
            end else if (wbm_ack_i) begin
               cyc_d  = 1'b0;
               tmo_d  = '0;
               rdat_d = wbm_dat_i;
               if (we_q) begin
                  tx_data_d  = RSP_OK;
                  tx_valid_d = 1'b1;
                  state_d    = RESP;
               end else begin
                  tx_data_d  = wbm_dat_i[7:0];
                  tx_valid_d = 1'b1;
                  byte_cnt_d = '0;
                  state_d    = SEND_DATA;
               end
            end else if (tmo_inc == TMO_WD'(TIMEOUT)) begin
               cyc_d      = 1'b0;
               tmo_d      = '0;
               err_d      = 1'b1;
               tx_data_d  = RSP_ERR;
               tx_valid_d = 1'b1;
               state_d    = RESP;
            end else begin
               tmo_d = tmo_inc;
            end
         end

         RESP: begin
            if (tx_fire) begin
               tx_valid_d = 1'b0;
               state_d    = GET_OP;
            end
         end

         SEND_DATA: begin
            if (tx_fire) begin
               if (byte_cnt_q == BC_WD'(DATA_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  tx_valid_d = 1'b0;
                  state_d    = GET_OP;
               end else begin
                  byte_cnt_d = byte_cnt_inc;
                  for (int i = 0; i < DATA_BYTES; i++) begin
                     if (byte_cnt_inc == BC_WD'(i)) tx_data_d = rdat_q[i*8 +: 8];
                  end
               end
            end
         end

         default: begin
            cyc_d      = 1'b0;
            tx_valid_d = 1'b0;
            state_d    = GET_OP;
         end
      endcase

      rx_ready_d = (state_d == GET_OP) || (state_d == GET_ADDR) || (state_d == GET_DATA);
      busy_d     = (state_d != GET_OP);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= GET_OP;
         byte_cnt_q <= '0;
         tmo_q      <= '0;
         addr_q     <= '0;
         wdat_q     <= '0;
         rdat_q     <= '0;
         we_q       <= 1'b0;
         cyc_q      <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         rx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_q      <= tmo_d;
         addr_q     <= addr_d;
         wdat_q     <= wdat_d;
         rdat_q     <= rdat_d;
         we_q       <= we_d;
         cyc_q      <= cyc_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         rx_ready_q <= rx_ready_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign rx_ready_o = rx_ready_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = cyc_q;
   assign wbm_we_o   = we_q;
   assign wbm_adr_o  = addr_q[ADDR_WD-1:0];
   assign wbm_dat_o  = wdat_q;
   assign wbm_sel_o  = '1;
   assign busy_o     = busy_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_sram_wb_cmd_master.sv
// Directed bench for sram_wb_cmd_master with TX and Wishbone scoreboards.
module tb_sram_wb_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        cyc, stb, we;
   logic [7:0]  adr;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic [31:0] slave_rdata;
   logic        ack, ack_q, late_ack;
   logic        busy, err;

   logic        slave_on;
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          stb_cycles = 0;
   int          err_cnt = 0;

   typedef struct packed {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
   } wb_exp_t;

   logic [7:0] exp_tx[$];
   wb_exp_t    exp_wb[$];

   always #5 clk = ~clk;

   assign ack = ack_q | late_ack;

   sram_wb_cmd_master #(.ADDR_WD(8), .DATA_WD(32), .TIMEOUT(255)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid),
      .rx_ready_o (rx_ready),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .wbm_cyc_o  (cyc),
      .wbm_stb_o  (stb),
      .wbm_we_o   (we),
      .wbm_adr_o  (adr),
      .wbm_dat_o  (dat_o),
      .wbm_sel_o  (sel),
      .wbm_dat_i  (slave_rdata),
      .wbm_ack_i  (ack),
      .busy_o     (busy),
      .err_o      (err)
   );

   // Slave acks one cycle after strobe and drops ack before any new request.
   always @(posedge clk or posedge rst) begin
      if (rst) ack_q <= 1'b0;
      else     ack_q <= slave_on && stb && !ack_q;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (stb) stb_cycles++;
         if (err) err_cnt++;
         if (tx_valid && tx_ready) begin
            logic [7:0] eb;
            eb = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
            chk("tx_byte", 64'(tx_data), 64'(eb));
         end
         if (stb && ack) begin
            wb_exp_t e;
            chk("wb_pending", 64'(exp_wb.size() > 0), 64'(1));
            if (exp_wb.size() > 0) begin
               e = exp_wb.pop_front();
               chk("wb_we", 64'(we), 64'(e.we));
               chk("wb_adr", 64'(adr), 64'(e.adr));
               chk("wb_sel", 64'(sel), 64'(4'hF));
               chk("wb_cyc", 64'(cyc), 64'(1));
               if (e.we) chk("wb_dat", 64'(dat_o), 64'(e.dat));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("rx_accept", 64'(rx_ready), 64'(1));
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx32(input logic [31:0] d);
      for (int i = 0; i < 4; i++) exp_tx.push_back(d[i*8 +: 8]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int eb;
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
      slave_on = 1'b1; slave_rdata = 32'h0; late_ack = 1'b0;
      #23;
      chk("rst_cyc", 64'(cyc), 64'(0));
      chk("rst_stb", 64'(stb), 64'(0));
      chk("rst_we", 64'(we), 64'(0));
      chk("rst_txv", 64'(tx_valid), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_adr", 64'(adr), 64'(0));
      chk("rst_dat", 64'(dat_o), 64'(0));
      chk("rst_txd", 64'(tx_data), 64'(0));
      chk("rst_sel", 64'(sel), 64'(4'hF));
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      // Write 0xDEADBEEF to 0x10.
      stb_cycles = 0;
      exp_wb.push_back('{we: 1'b1, adr: 8'h10, dat: 32'hDEADBEEF});
      exp_tx.push_back(8'h4B);
      send_byte(8'h57); send_byte(8'h10);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      wait_idle(100);
      chk("wr_stb_len", 64'(stb_cycles), 64'(2));

      // Read back from 0x10.
      slave_rdata = 32'hDEADBEEF;
      stb_cycles = 0;
      exp_wb.push_back('{we: 1'b0, adr: 8'h10, dat: 32'h0});
      push_tx32(32'hDEADBEEF);
      send_byte(8'h52); send_byte(8'h10);
      wait_idle(100);
      chk("rd_tx_drained", 64'(exp_tx.size()), 64'(0));
      chk("rd_txv_low", 64'(tx_valid), 64'(0));
      chk("rd_stb_len", 64'(stb_cycles), 64'(2));

      // Bad opcode then a normal write.
      stb_cycles = 0;
      eb = err_cnt;
      exp_tx.push_back(8'h45);
      send_byte(8'h33);
      wait_idle(100);
      chk("bad_no_wb", 64'(stb_cycles), 64'(0));
      chk("bad_err_pulse", 64'(err_cnt - eb), 64'(1));
      exp_wb.push_back('{we: 1'b1, adr: 8'h3C, dat: 32'h12345678});
      exp_tx.push_back(8'h4B);
      send_byte(8'h57); send_byte(8'h3C);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      wait_idle(100);
      chk("bad_then_wr", 64'(exp_wb.size()), 64'(0));

      // Timeout with silent slave, then a late ack.
      slave_on = 1'b0;
      stb_cycles = 0;
      eb = err_cnt;
      exp_tx.push_back(8'h45);
      send_byte(8'h52); send_byte(8'h20);
      wait_idle(400);
      chk("tmo_stb_len", 64'(stb_cycles), 64'(255));
      chk("tmo_err_pulse", 64'(err_cnt - eb), 64'(1));
      repeat (8) @(posedge clk);
      #1; late_ack = 1'b1;
      @(posedge clk); #1; late_ack = 1'b0;
      eb = err_cnt;
      repeat (5) @(posedge clk);
      #4;
      chk("late_busy", 64'(busy), 64'(0));
      chk("late_stb", 64'(stb), 64'(0));
      chk("late_txv", 64'(tx_valid), 64'(0));
      chk("late_err", 64'(err_cnt - eb), 64'(0));
      chk("late_rdy", 64'(rx_ready), 64'(1));
      @(posedge clk); #1;

      // TX backpressure during a read.
      slave_on = 1'b1;
      slave_rdata = 32'hCAFE1234;
      tx_ready = 1'b0;
      exp_wb.push_back('{we: 1'b0, adr: 8'h5A, dat: 32'h0});
      push_tx32(32'hCAFE1234);
      send_byte(8'h52); send_byte(8'h5A);
      begin
         int n = 0;
         @(negedge clk);
         while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      for (int i = 0; i < 20; i++) begin
         chk("bp_txd", 64'(tx_data), 64'(8'h34));
         chk("bp_txv", 64'(tx_valid), 64'(1));
         chk("bp_rxrdy", 64'(rx_ready), 64'(0));
         @(negedge clk);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_idle(100);
      chk("bp_drained", 64'(exp_tx.size()), 64'(0));

      // Reset while strobe is high.
      slave_on = 1'b0;
      send_byte(8'h57); send_byte(8'h01);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      begin
         int n = 0;
         @(negedge clk);
         while (!stb && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      chk("mid_stb_up", 64'(stb), 64'(1));
      #2; rst = 1'b1;
      #1;
      chk("mid_rst_cyc", 64'(cyc), 64'(0));
      chk("mid_rst_stb", 64'(stb), 64'(0));
      chk("mid_rst_txv", 64'(tx_valid), 64'(0));
      @(posedge clk); #1; rst = 1'b0;
      slave_on = 1'b1;
      slave_rdata = 32'h0BADF00D;
      exp_wb.push_back('{we: 1'b0, adr: 8'h77, dat: 32'h0});
      push_tx32(32'h0BADF00D);
      send_byte(8'h52); send_byte(8'h77);
      wait_idle(100);
      chk("end_tx_q", 64'(exp_tx.size()), 64'(0));
      chk("end_wb_q", 64'(exp_wb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
